// File: rtl/spectrum_bar_binner.sv
// Reduces the positive-frequency half of an FFT magnitude frame to NUM_BARS bar heights
// with group-max, scaling, clamping and per-bar peak-hold with linear decay.
module spectrum_bar_binner #(
   parameter int N        = 256,
   parameter int NUM_BARS = 32,
   parameter int MAG_W    = 14,
   parameter int BAR_W    = 9,
   parameter int BAR_MAX  = 440,
   parameter int SHIFT    = 5,
   parameter int DECAY    = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 fft_done,
   input  logic [0:N-1][MAG_W-1:0]              freq_samples,
   output logic [0:NUM_BARS-1][BAR_W-1:0]       bars,
   output logic                                 bars_valid,
   output logic                                 busy
);

   localparam int HALF = N / 2;
   localparam int BPB  = HALF / NUM_BARS;
   localparam int K_W  = $clog2(HALF);
   localparam int B_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t                  state, state_nxt;
   logic                    done_q;
   logic                    start;
   logic                    scan_en;
   logic                    commit_en;
   logic [K_W-1:0]          k;
   logic [B_W-1:0]          bar_idx;
   logic                    first_bin;
   logic [MAG_W-1:0]        mag;
   logic [MAG_W-1:0]        grp [NUM_BARS];

   // Peak-hold: a taller new height replaces the bar, otherwise the bar falls by DECAY.
   function automatic logic [BAR_W-1:0] next_height(input logic [MAG_W-1:0] g,
                                                    input logic [BAR_W-1:0] cur);
      logic [MAG_W-1:0] s;
      logic [BAR_W-1:0] h;
      s = g >> SHIFT;
      h = (s > MAG_W'(BAR_MAX)) ? BAR_W'(BAR_MAX) : s[BAR_W-1:0];
      if (h >= cur)
         return h;
      else if (cur > BAR_W'(DECAY))
         return cur - BAR_W'(DECAY);
      else
         return '0;
   endfunction

   assign start     = fft_done & ~done_q;
   assign bar_idx   = B_W'(int'(k) / BPB);
   assign first_bin = (int'(k) % BPB) == 0;
   assign mag       = (k == '0) ? '0 : freq_samples[k];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (k == K_W'(HALF - 1)) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      scan_en   = (state == SCAN);
      commit_en = (state == COMMIT);
      busy      = (state != IDLE);
   end

   // done_q follows fft_done even in reset so a level held across release is not an edge.
   always_ff @(posedge clk) begin
      done_q <= fft_done;
      if (rst) begin
         k          <= '0;
         bars       <= '0;
         bars_valid <= 1'b0;
         for (int b = 0; b < NUM_BARS; b++) grp[b] <= '0;
      end else begin
         bars_valid <= commit_en;
         if (state == IDLE && start) k <= '0;
         if (scan_en) begin
            k <= k + 1'b1;
            if (first_bin || mag > grp[bar_idx]) grp[bar_idx] <= mag;
         end
         if (commit_en) begin
            for (int b = 0; b < NUM_BARS; b++) bars[b] <= next_height(grp[b], bars[b]);
         end
      end
   end

endmodule

// File: tb/tb_spectrum_bar_binner.sv
// Directed bench for spectrum_bar_binner: latency, binning, clamp, decay, ignored edges, reset abort.
module tb_spectrum_bar_binner;

   logic                clk = 1'b0;
   logic                rst;
   logic                fft_done;
   logic [0:255][13:0]  fs;
   logic [0:31][8:0]    bars;
   logic                bars_valid;
   logic                busy;
   logic [0:31][8:0]    exp_bars;

   int n_cmp = 0;
   int n_err = 0;

   spectrum_bar_binner dut (
      .clk          (clk),
      .rst          (rst),
      .fft_done     (fft_done),
      .freq_samples (fs),
      .bars         (bars),
      .bars_valid   (bars_valid),
      .busy         (busy)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raises fft_done, waits for the bars_valid pulse and checks its latency and width.
   // The pulse is seen on tick 130: tick 1 is the edge-detect cycle, commit is 129 later.
   task automatic run_frame(input string tag);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 0;
      fft_done = 1'b1;
      while (cnt < 300 && !seen) begin
         tick();
         cnt++;
         if (bars_valid) seen = 1;
      end
      check({tag, "_latency"}, cnt, 130);
      fft_done = 1'b0;
      tick();
      check({tag, "_valid_pulse"}, bars_valid, 1'b0);
      check({tag, "_busy_after"}, busy, 1'b0);
   endtask

   initial begin
      int pulses;
      int lat;
      rst      = 1'b1;
      fft_done = 1'b0;
      fs       = '0;
      exp_bars = '0;
      repeat (3) tick();
      check("reset_bars", bars, '0);
      check("reset_valid", bars_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      // Test 1: all zero magnitudes
      fft_done = 1'b1;
      tick();
      tick();
      check("t1_busy_in_scan", busy, 1'b1);
      fft_done = 1'b0;
      repeat (200) tick();
      check("t1_idle_after", busy, 1'b0);
      run_frame("t1");
      check("t1_bars", bars, '0);

      // Test 3: DC only is suppressed, then bin 127 full scale clamps
      fs[0] = 14'd16383;
      run_frame("t3_dc");
      check("t3_dc_bars", bars, '0);
      fs = '0;
      fs[127] = 14'd16383;
      run_frame("t3_clamp");
      exp_bars = '0;
      exp_bars[31] = 9'd440;
      check("t3_clamp_bars", bars, exp_bars);
      check("t3_clamp_bar31", bars[31], 9'd440);

      // Reset clears bars that hold a value
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_clears_bars", bars, '0);

      // Test 2 / group max: bar1=3200>>5=100, bar2=max(1000,2000,500)>>5=62
      fs = '0;
      fs[5]  = 14'd3200;
      fs[8]  = 14'd1000;
      fs[9]  = 14'd2000;
      fs[11] = 14'd500;
      run_frame("t2");
      exp_bars = '0;
      exp_bars[1] = 9'd100;
      exp_bars[2] = 9'd62;
      check("t2_bars", bars, exp_bars);

      // bar2 = 128>>5 = 4, lower than 62, so it decays to 56 instead
      fs = '0;
      fs[5]  = 14'd3200;
      fs[10] = 14'd128;
      run_frame("t2b");
      exp_bars[1] = 9'd100;
      exp_bars[2] = 9'd56;
      check("t2b_bars", bars, exp_bars);

      // Test 4: decay on zero frames
      fs = '0;
      run_frame("t4_f1");
      exp_bars[1] = 9'd94;
      exp_bars[2] = 9'd50;
      check("t4_f1_bars", bars, exp_bars);
      run_frame("t4_f2");
      check("t4_f2_bar1", bars[1], 9'd88);
      run_frame("t4_f3");
      check("t4_f3_bar1", bars[1], 9'd82);

      // Taller new height replaces; a small one only decays
      fs[5]  = 14'd2720;
      fs[10] = 14'd128;
      run_frame("t4_hold");
      check("t4_hold_bar1", bars[1], 9'd85);
      check("t4_hold_bar2", bars[2], 9'd32);
      fs[5] = 14'd320;
      fs[10] = 14'd0;
      run_frame("t4_drop");
      check("t4_drop_bar1", bars[1], 9'd79);
      check("t4_drop_bar2", bars[2], 9'd26);

      // Bar at 4 floors to 0 with no wrap
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fs = '0;
      fs[10] = 14'd128;
      run_frame("t4_four");
      check("t4_four_bar2", bars[2], 9'd4);
      fs = '0;
      run_frame("t4_floor");
      check("t4_floor_bars", bars, '0);

      // Test 5: second edge mid-scan is ignored
      fs[5] = 14'd3200;
      fft_done = 1'b1;
      pulses = 0;
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 49) fft_done = 1'b0;
         if (i == 50) begin
            check("t5_busy_mid", busy, 1'b1);
            fft_done = 1'b1;
         end
         if (bars_valid) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      check("t5_pulses", pulses, 1);
      check("t5_latency", lat, 130);
      check("t5_bar1", bars[1], 9'd100);
      fft_done = 1'b0;
      tick();
      fs = '0;
      run_frame("t5_next");
      check("t5_next_bar1", bars[1], 9'd94);

      // Test 6: reset mid-scan with fft_done held high
      fs[5] = 14'd3200;
      fft_done = 1'b1;
      repeat (60) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t6_bars_cleared", bars, '0);
      check("t6_idle", busy, 1'b0);
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bars_valid || busy) pulses++;
      end
      check("t6_no_scan", pulses, 0);
      check("t6_bars_still_zero", bars, '0);
      fft_done = 1'b0;
      tick();
      run_frame("t6_restart");
      exp_bars = '0;
      exp_bars[1] = 9'd100;
      check("t6_restart_bars", bars, exp_bars);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
